except_handler: RTL
===================

Name: except_handler

Overview:
- Trap controller that consumes the 7-bit execute-stage exception vector.
- When an exception fires it prioritises the bits, latches cause/PC/address, flushes the pipeline, and redirects fetch to the trap vector.
- Sequences the return from trap on `mret`.
- Sits beside the E/M pipeline register and drives the fetch-PC mux and the pipeline flush/stall lines.

Parameters:
- N, 64, data/address width
- FLUSH_CYCLES, 2, cycles `flush` is held before redirect (≥1)
- MTVEC, 64'h0000_0000_0000_0100, trap handler entry address

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- E_valid  in  1  execute stage holds a real (non-bubble) instruction
- exceptSignal  in  7  exception vector:
  - bit0 load misalign, bit1 load access fault, bit2 store misalign, bit3 store access fault
  - bit4 load page fault, bit5 store page fault, bit6 breakpoint
- E_pc  in  N  PC of execute-stage instruction
- DM_addr  in  N  data address of execute-stage instruction
- mret  in  1  execute stage holds `mret` (qualified by E_valid)
- flush  out  1  squash IF/ID/E instructions
- stall  out  1  freeze PC and pipeline registers
- pc_redirect  out  1  fetch takes redirect_pc this cycle
- redirect_pc  out  N  target PC
- in_trap  out  1  core is executing the handler
- mepc  out  N  latched faulting PC
- mcause  out  N  latched cause code, zero-extended
- mtval  out  N  latched trap value

Behaviour:
- Interface: one clock `clk`; reset `reset` is synchronous and active-high. All outputs are registered or decoded from state/registers only; there are no combinational input-to-output paths.
- Reset values: state IDLE, count 0; all outputs 0, including `redirect_pc`, `mepc`, `mcause` and `mtval`. Reset asserted in any state returns to IDLE on that edge, cancelling any flush or redirect in progress.
- take = E_valid & (|exceptSignal) & state∈{IDLE,TRAP}.
- Priority and cause code (RISC-V), highest first:
  - bit6 → 3
  - bit2 → 6, bit0 → 4
  - bit5 → 15, bit4 → 13
  - bit3 → 7, bit1 → 5
- On take, at the edge:
  - mepc←E_pc; mcause←code
  - mtval←E_pc if breakpoint, else DM_addr
  - count←FLUSH_CYCLES-1; →FLUSH
- FLUSH:
  - flush=1, stall=1
  - count==0 → REDIRECT; otherwise decrement
  - exceptSignal and mret are ignored.
- REDIRECT (1 cycle):
  - pc_redirect=1, redirect_pc=MTVEC, flush=1, stall=0
  - → TRAP
- TRAP:
  - in_trap=1
  - take has priority over mret. A nested take overwrites mepc/mcause/mtval and re-enters FLUSH.
  - E_valid&mret&~take → RET.
- RET (1 cycle):
  - pc_redirect=1, redirect_pc=mepc, flush=1, in_trap=1
  - → IDLE
- IDLE: mret is ignored (no trap is active); redirect_pc holds its last value.
- Latency: exception in cycle t → flush from t+1 for FLUSH_CYCLES+1 cycles → pc_redirect at t+1+FLUSH_CYCLES.
- exceptSignal with E_valid=0 is ignored in every state.

Optional Feature:
- Macro: EXCEPT_HANDLER_MTVAL_EN.
- Defined: mtval is a register captured as described above.
- Undefined: mtval is tied to 0 and no mtval flops exist. All other behaviour is unchanged.

Decomposition:
- Package `except_pkg`:
  - bit-index localparams for the 7-bit vector
  - cause-code constants (3, 4, 5, 6, 7, 13, 15)
  - enum `except_state_t` {IDLE, FLUSH, REDIRECT, TRAP, RET}
- One sub-module, `except_prio`: combinational priority encoder from exceptSignal[6:0] to {valid, cause[3:0], is_bkpt}.

Test Plan:
- Reset mid-FLUSH: trigger exception, assert reset at the next cycle → next cycle state IDLE, all outputs 0, no pc_redirect ever.
- Load misalign: E_valid=1, exceptSignal=7'b0000001, E_pc=0x40, DM_addr=0x1003, FLUSH_CYCLES=2. Required:
  - flush high for cycles t+1..t+3
  - pc_redirect=1 with redirect_pc=0x100 at t+3
  - mepc=0x40, mcause=4, mtval=0x1003, in_trap=1 from t+4
- Priority: exceptSignal=7'b1100101 with E_pc=0x80 → mcause=3 and mtval=0x80.
  - Then with exceptSignal=7'b0100100 → mcause=6.
  - Then with exceptSignal=7'b0001000 → mcause=7.
- Return: in TRAP, mret=1 with E_valid=1 → next cycle pc_redirect=1, redirect_pc=0x40, flush=1; the following cycle IDLE with in_trap=0.
  - mret while IDLE → no response.
- Simultaneous events:
  - In TRAP, mret=1 with exceptSignal=7'b0010000 and E_pc=0x104 → enters FLUSH, mcause=13, mepc=0x104, no RET.
  - Exception asserted during FLUSH → ignored; mepc unchanged.
- Gating: exceptSignal=7'b0000100 with E_valid=0 → no flush.
  - Build without EXCEPT_HANDLER_MTVAL_EN → mtval stays 0 after the store misalign.

Source files
------------

// File: rtl/except_handler_pkg.sv
// +-----------------------------------------------------------------------------+
// | Module   : except_pkg                                                       |
// | Purpose  : Exception bit indices, RISC-V cause codes and trap FSM states.   |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
`default_nettype none

package except_pkg;

    localparam int c_bit_ld_misalign = 0;
    localparam int c_bit_ld_fault    = 1;
    localparam int c_bit_st_misalign = 2;
    localparam int c_bit_st_fault    = 3;
    localparam int c_bit_ld_page     = 4;
    localparam int c_bit_st_page     = 5;
    localparam int c_bit_bkpt        = 6;

    localparam logic [3:0] c_cause_bkpt        = 4'd3;
    localparam logic [3:0] c_cause_ld_misalign = 4'd4;
    localparam logic [3:0] c_cause_ld_fault    = 4'd5;
    localparam logic [3:0] c_cause_st_misalign = 4'd6;
    localparam logic [3:0] c_cause_st_fault    = 4'd7;
    localparam logic [3:0] c_cause_ld_page     = 4'd13;
    localparam logic [3:0] c_cause_st_page     = 4'd15;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FLUSH    = 3'd1,
        REDIRECT = 3'd2,
        TRAP     = 3'd3,
        RET      = 3'd4
    } except_state_t;

endpackage

`default_nettype wire

// File: rtl/except_handler_if.sv
// +-----------------------------------------------------------------------------+
// | Module   : except_handler_if                                                |
// | Purpose  : Execute-stage exception inputs and fetch/pipeline control lines. |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
`default_nettype none

interface except_handler_if #(
    parameter int N = 64
);
    logic         E_valid;
    logic [6:0]   exceptSignal;
    logic [N-1:0] E_pc;
    logic [N-1:0] DM_addr;
    logic         mret;
    logic         flush;
    logic         stall;
    logic         pc_redirect;
    logic [N-1:0] redirect_pc;
    logic         in_trap;
    logic [N-1:0] mepc;
    logic [N-1:0] mcause;
    logic [N-1:0] mtval;

    // pipeline side
    modport master (
        output E_valid, exceptSignal, E_pc, DM_addr, mret,
        input  flush, stall, pc_redirect, redirect_pc, in_trap, mepc, mcause, mtval
    );

    // trap controller side
    modport slave (
        input  E_valid, exceptSignal, E_pc, DM_addr, mret,
        output flush, stall, pc_redirect, redirect_pc, in_trap, mepc, mcause, mtval
    );
endinterface

`default_nettype wire

// File: rtl/except_handler_prio.sv
// +-----------------------------------------------------------------------------+
// | Module   : except_prio                                                      |
// | Purpose  : Priority encoder from the 7-bit exception vector to cause code.  |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
`default_nettype none

module except_prio
    import except_pkg::*;
(
    input  wire logic [6:0] i_except,
    output logic            o_valid,
    output logic [3:0]      o_cause,
    output logic            o_is_bkpt
);

    always_comb begin
        o_valid   = |i_except;
        o_is_bkpt = 1'b0;
        o_cause   = 4'd0;
        // Breakpoint, then misaligned, then page faults, then access faults
        if (i_except[c_bit_bkpt]) begin
            o_cause   = c_cause_bkpt;
            o_is_bkpt = 1'b1;
        end else if (i_except[c_bit_st_misalign]) begin
            o_cause = c_cause_st_misalign;
        end else if (i_except[c_bit_ld_misalign]) begin
            o_cause = c_cause_ld_misalign;
        end else if (i_except[c_bit_st_page]) begin
            o_cause = c_cause_st_page;
        end else if (i_except[c_bit_ld_page]) begin
            o_cause = c_cause_ld_page;
        end else if (i_except[c_bit_st_fault]) begin
            o_cause = c_cause_st_fault;
        end else if (i_except[c_bit_ld_fault]) begin
            o_cause = c_cause_ld_fault;
        end
    end

endmodule

`default_nettype wire

// File: rtl/except_handler.sv
// +-----------------------------------------------------------------------------+
// | Module   : except_handler                                                   |
// | Purpose  : Trap controller: latches cause/PC/value, flushes, redirects.     |
// |            Optional macro EXCEPT_HANDLER_MTVAL_EN enables the mtval reg.    |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
`default_nettype none

module except_handler
    import except_pkg::*;
#(
    parameter int          N            = 64,
    parameter int          FLUSH_CYCLES = 2,
    parameter logic [63:0] MTVEC        = 64'h0000_0000_0000_0100
) (
    input  wire logic          clk,
    input  wire logic          reset,
    except_handler_if.slave    bus
);

    localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    except_state_t  r_state;
    logic [CW-1:0]  r_count;
    logic           r_flush;
    logic           r_stall;
    logic           r_pc_redirect;
    logic [N-1:0]   r_redirect_pc;
    logic           r_in_trap;
    logic [N-1:0]   r_mepc;
    logic [3:0]     r_mcause;

    logic           w_valid;
    logic [3:0]     w_cause;
    logic           w_is_bkpt;
    logic           w_take;

    except_prio u_prio (
        .i_except  (bus.exceptSignal),
        .o_valid   (w_valid),
        .o_cause   (w_cause),
        .o_is_bkpt (w_is_bkpt)
    );

    assign w_take = bus.E_valid & w_valid & ((r_state == IDLE) | (r_state == TRAP));

    // Outputs are assigned for the state being entered, so they are flop-driven
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_count       <= '0;
            r_flush       <= 1'b0;
            r_stall       <= 1'b0;
            r_pc_redirect <= 1'b0;
            r_redirect_pc <= '0;
            r_in_trap     <= 1'b0;
            r_mepc        <= '0;
            r_mcause      <= '0;
        end else begin
            case (r_state)
                IDLE, TRAP: begin
                    if (w_take) begin
                        r_state       <= FLUSH;
                        r_count       <= CW'(FLUSH_CYCLES - 1);
                        r_mepc        <= bus.E_pc;
                        r_mcause      <= w_cause;
                        r_flush       <= 1'b1;
                        r_stall       <= 1'b1;
                        r_pc_redirect <= 1'b0;
                        r_in_trap     <= 1'b0;
                    end else if ((r_state == TRAP) && bus.E_valid && bus.mret) begin
                        r_state       <= RET;
                        r_pc_redirect <= 1'b1;
                        r_redirect_pc <= r_mepc;
                        r_flush       <= 1'b1;
                        r_stall       <= 1'b0;
                        r_in_trap     <= 1'b1;
                    end else begin
                        r_flush       <= 1'b0;
                        r_stall       <= 1'b0;
                        r_pc_redirect <= 1'b0;
                        r_in_trap     <= (r_state == TRAP);
                    end
                end
                FLUSH: begin
                    if (r_count == '0) begin
                        r_state       <= REDIRECT;
                        r_pc_redirect <= 1'b1;
                        r_redirect_pc <= MTVEC[N-1:0];
                        r_flush       <= 1'b1;
                        r_stall       <= 1'b0;
                    end else begin
                        r_count <= r_count - CW'(1);
                    end
                end
                REDIRECT: begin
                    r_state       <= TRAP;
                    r_pc_redirect <= 1'b0;
                    r_flush       <= 1'b0;
                    r_stall       <= 1'b0;
                    r_in_trap     <= 1'b1;
                end
                RET: begin
                    r_state       <= IDLE;
                    r_pc_redirect <= 1'b0;
                    r_flush       <= 1'b0;
                    r_stall       <= 1'b0;
                    r_in_trap     <= 1'b0;
                end
                default: begin
                    r_state       <= IDLE;
                    r_pc_redirect <= 1'b0;
                    r_flush       <= 1'b0;
                    r_stall       <= 1'b0;
                    r_in_trap     <= 1'b0;
                end
            endcase
        end
    end

`ifdef EXCEPT_HANDLER_MTVAL_EN
    logic [N-1:0] r_mtval;

    // Breakpoints report the faulting PC; memory faults report the data address
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mtval <= '0;
        end else if (w_take) begin
            r_mtval <= w_is_bkpt ? bus.E_pc : bus.DM_addr;
        end
    end

    assign bus.mtval = r_mtval;
`else
    logic w_unused;
    assign w_unused  = ^{bus.DM_addr, w_is_bkpt};
    assign bus.mtval = '0;
`endif

    assign bus.flush       = r_flush;
    assign bus.stall       = r_stall;
    assign bus.pc_redirect = r_pc_redirect;
    assign bus.redirect_pc = r_redirect_pc;
    assign bus.in_trap     = r_in_trap;
    assign bus.mepc        = r_mepc;
    assign bus.mcause      = {{(N-4){1'b0}}, r_mcause};

endmodule

`default_nettype wire
